// File: rtl/pump_ctrl_pkg.sv
// Shared level codes, controller state encoding and level helpers.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package pump_ctrl_pkg;

    // One-hot level codes as produced by the level encoder
    localparam logic [2:0] LVL_ERR  = 3'b000;
    localparam logic [2:0] LVL_LOW  = 3'b001;
    localparam logic [2:0] LVL_MED  = 3'b010;
    localparam logic [2:0] LVL_HIGH = 3'b100;

    // Controller state; the encoding is visible on ctrl_state
    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        FILL  = 2'b01,
        REST  = 2'b10,
        FAULT = 2'b11
    } ctrl_state_t;

    // A level code is usable only if it is exactly one of the three one-hot codes
    function automatic logic lvl_is_valid(input logic [2:0] lvl);
        return (lvl == LVL_LOW) || (lvl == LVL_MED) || (lvl == LVL_HIGH);
    endfunction

endpackage

// File: rtl/level_debounce.sv
// Debounces the raw level code and tracks runs of invalid raw samples.
// Latency: a code held for STABLE_CYCLES samples is accepted on the edge of its last sample.
// Backpressure: none; consumes one sample every cycle.
module level_debounce
    import pump_ctrl_pkg::*;
#(
    parameter int CNT_W         = 16,
    parameter int STABLE_CYCLES = 4,
    parameter int FAULT_CYCLES  = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] sample,
    output logic [2:0] accepted,
    output logic       level_valid,
    output logic       inval_hit,
    output logic       inval_zero
);

    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] STABLE_N = CNT_W'(STABLE_CYCLES);
    localparam logic [CNT_W-1:0] FAULT_N  = CNT_W'(FAULT_CYCLES);

    logic [2:0]       candidate;
    logic [CNT_W-1:0] stable_cnt;
    logic [CNT_W-1:0] stable_nxt;
    logic [CNT_W-1:0] inval_cnt;
    logic             sample_invalid;

    // Length of the current run of identical samples, including this one
    always_comb begin
        stable_nxt = CNT_ONE;
        if (sample == candidate) begin
            stable_nxt = (stable_cnt == CNT_MAX) ? stable_cnt : stable_cnt + CNT_ONE;
        end
    end

    // Raw-sample validity drives the fault path independently of debouncing
    always_comb begin
        sample_invalid = !lvl_is_valid(sample);
    end

    // Candidate/run tracking; accepted follows once the run is long enough
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            candidate  <= LVL_ERR;
            stable_cnt <= '0;
            accepted   <= LVL_ERR;
        end else begin
            candidate  <= sample;
            stable_cnt <= stable_nxt;
            if (stable_nxt >= STABLE_N) begin
                accepted <= sample;
            end
        end
    end

    // Consecutive invalid samples, saturating; any valid sample clears the run
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            inval_cnt <= '0;
        end else if (sample_invalid) begin
            if (inval_cnt != CNT_MAX) begin
                inval_cnt <= inval_cnt + CNT_ONE;
            end
        end else begin
            inval_cnt <= '0;
        end
    end

    assign level_valid = lvl_is_valid(accepted);
    assign inval_hit   = (inval_cnt >= FAULT_N);
    assign inval_zero  = (inval_cnt == '0);

endmodule

// File: rtl/pump_level_controller.sv
// Fill-pump controller: hysteresis on debounced level, dry-run timeout, rest time, fault latch.
// Latency: accepted level change -> pump_on/fault/ctrl_state update on the following edge.
// Backpressure: none; level code is sampled every cycle, outputs are level signals.
module pump_level_controller
    import pump_ctrl_pkg::*;
#(
    parameter int CNT_W          = 16,
    parameter int STABLE_CYCLES  = 4,
    parameter int FAULT_CYCLES   = 8,
    parameter int MAX_RUN_CYCLES = 1000,
    parameter int MIN_OFF_CYCLES = 50
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] water_level_state,
    input  logic       enable,
    input  logic       clear_fault,
    output logic       pump_on,
    output logic       fault,
    output logic       level_valid,
    output logic [1:0] ctrl_state
);

    // Reject parameter sets the counters cannot represent
    localparam longint CNT_LIMIT = longint'(1) << CNT_W;

    if (CNT_W < 1 || CNT_W > 32) begin : g_bad_cnt_w
        $error("pump_level_controller: CNT_W must be in 1..32");
    end
    if (STABLE_CYCLES < 1 || longint'(STABLE_CYCLES) >= CNT_LIMIT) begin : g_bad_stable
        $error("pump_level_controller: STABLE_CYCLES out of range");
    end
    if (FAULT_CYCLES < 1 || longint'(FAULT_CYCLES) >= CNT_LIMIT) begin : g_bad_fault
        $error("pump_level_controller: FAULT_CYCLES out of range");
    end
    if (MAX_RUN_CYCLES < 1 || longint'(MAX_RUN_CYCLES) >= CNT_LIMIT) begin : g_bad_run
        $error("pump_level_controller: MAX_RUN_CYCLES out of range");
    end
    if (MIN_OFF_CYCLES < 1 || longint'(MIN_OFF_CYCLES) >= CNT_LIMIT) begin : g_bad_off
        $error("pump_level_controller: MIN_OFF_CYCLES out of range");
    end

    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] RUN_LAST = CNT_W'(MAX_RUN_CYCLES - 1);
    localparam logic [CNT_W-1:0] OFF_LAST = CNT_W'(MIN_OFF_CYCLES - 1);

    logic [2:0]       accepted;
    logic             inval_hit;
    logic             inval_zero;
    ctrl_state_t      state_q;
    ctrl_state_t      state_d;
    logic [CNT_W-1:0] run_cnt;
    logic [CNT_W-1:0] off_cnt;

    level_debounce #(
        .CNT_W         (CNT_W),
        .STABLE_CYCLES (STABLE_CYCLES),
        .FAULT_CYCLES  (FAULT_CYCLES)
    ) u_debounce (
        .clk         (clk),
        .reset       (reset),
        .sample      (water_level_state),
        .accepted    (accepted),
        .level_valid (level_valid),
        .inval_hit   (inval_hit),
        .inval_zero  (inval_zero)
    );

    // Next-state: invalid run beats everything; an accepted HIGH stops the
    // pump even on the cycle the dry-run limit would otherwise trip
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (inval_hit) begin
                    state_d = FAULT;
                end else if (accepted == LVL_LOW && enable) begin
                    state_d = FILL;
                end
            end
            FILL: begin
                if (inval_hit) begin
                    state_d = FAULT;
                end else if (accepted == LVL_HIGH) begin
                    state_d = REST;
                end else if (run_cnt == RUN_LAST) begin
                    state_d = FAULT;
                end else if (!enable) begin
                    state_d = REST;
                end
            end
            REST: begin
                if (inval_hit) begin
                    state_d = FAULT;
                end else if (off_cnt == OFF_LAST) begin
                    state_d = IDLE;
                end
            end
            FAULT: begin
                // Leaving a fault always passes through REST so the pump gets its rest time
                if (clear_fault && level_valid && inval_zero) begin
                    state_d = REST;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State register with outputs decoded from next state so they change with it
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            pump_on <= 1'b0;
            fault   <= 1'b0;
        end else begin
            state_q <= state_d;
            pump_on <= (state_d == FILL);
            fault   <= (state_d == FAULT);
        end
    end

    // Run timer: zero outside FILL, so each fill starts counting from zero
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            run_cnt <= '0;
        end else if (state_q != FILL) begin
            run_cnt <= '0;
        end else if (run_cnt != CNT_MAX) begin
            run_cnt <= run_cnt + CNT_ONE;
        end
    end

    // Rest timer: zero outside REST, so every rest period is served in full
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            off_cnt <= '0;
        end else if (state_q != REST) begin
            off_cnt <= '0;
        end else if (off_cnt != CNT_MAX) begin
            off_cnt <= off_cnt + CNT_ONE;
        end
    end

    assign ctrl_state = state_q;

endmodule

// File: tb/tb_pump_level_controller.sv
// Scoreboard bench: driver pushes reference-model expectations, monitor compares each cycle.
// Latency: expectations target the edge following each driven sample.
// Backpressure: none; one expectation per clock edge.
module tb_pump_level_controller;

    localparam int ST = 4;
    localparam int FC = 8;
    localparam int MR = 20;
    localparam int MO = 5;

    localparam int M_IDLE  = 0;
    localparam int M_FILL  = 1;
    localparam int M_REST  = 2;
    localparam int M_FAULT = 3;

    logic       clk;
    logic       reset;
    logic [2:0] water_level_state;
    logic       enable;
    logic       clear_fault;
    logic       pump_on;
    logic       fault;
    logic       level_valid;
    logic [1:0] ctrl_state;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state: sample history, accepted level, mode, time in mode
    int hist[$];
    int acc;
    int mode;
    int fill_age;
    int rest_age;

    logic [4:0] exp_q[$];
    logic [4:0] mon_exp;
    logic [4:0] mon_got;

    pump_level_controller #(
        .CNT_W          (16),
        .STABLE_CYCLES  (ST),
        .FAULT_CYCLES   (FC),
        .MAX_RUN_CYCLES (MR),
        .MIN_OFF_CYCLES (MO)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .water_level_state (water_level_state),
        .enable            (enable),
        .clear_fault       (clear_fault),
        .pump_on           (pump_on),
        .fault             (fault),
        .level_valid       (level_valid),
        .ctrl_state        (ctrl_state)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    function automatic bit is_valid(int v);
        return (v == 1) || (v == 2) || (v == 4);
    endfunction

    function automatic int trailing_invalid();
        int n = 0;
        for (int i = hist.size() - 1; i >= 0; i--) begin
            if (is_valid(hist[i])) break;
            n++;
        end
        return n;
    endfunction

    task automatic model_reset();
        hist.delete();
        acc      = 0;
        mode     = M_IDLE;
        fill_age = 0;
        rest_age = 0;
    endtask

    // One clock edge of the controller as described in words: decide on the
    // level/invalid history seen so far, then absorb the new sample
    function automatic logic [4:0] model_step(int lvl, bit en, bit clr);
        int inv;
        int nm;
        bit same;
        inv = trailing_invalid();
        nm  = mode;
        if (mode == M_FAULT) begin
            if (clr && is_valid(acc) && inv == 0) nm = M_REST;
        end else if (inv >= FC) begin
            nm = M_FAULT;
        end else if (mode == M_IDLE) begin
            if (acc == 1 && en) nm = M_FILL;
        end else if (mode == M_FILL) begin
            if (acc == 4)                nm = M_REST;
            else if (fill_age + 1 >= MR) nm = M_FAULT;
            else if (!en)                nm = M_REST;
        end else begin
            if (rest_age + 1 >= MO) nm = M_IDLE;
        end
        fill_age = (mode == M_FILL) ? fill_age + 1 : 0;
        rest_age = (mode == M_REST) ? rest_age + 1 : 0;
        mode = nm;
        hist.push_back(lvl);
        if (hist.size() > 32) void'(hist.pop_front());
        if (hist.size() >= ST) begin
            same = 1'b1;
            for (int i = 1; i <= ST; i++) begin
                if (hist[hist.size() - i] != lvl) same = 1'b0;
            end
            if (same) acc = lvl;
        end
        return {(nm == M_FILL), (nm == M_FAULT), is_valid(acc), 2'(nm)};
    endfunction

    task automatic step(int lvl, bit en, bit clr);
        @(negedge clk);
        reset             = 1'b0;
        water_level_state = 3'(lvl);
        enable            = en;
        clear_fault       = clr;
        exp_q.push_back(model_step(lvl, en, clr));
    endtask

    task automatic settle();
        @(posedge clk);
        #2;
    endtask

    task automatic expect_now(string name, int got, int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Monitor: every edge out of reset has one expectation waiting
    always @(posedge clk) begin
        #1;
        if (!reset && exp_q.size() > 0) begin
            mon_exp = exp_q.pop_front();
            mon_got = {pump_on, fault, level_valid, ctrl_state};
            n_checks++;
            if (mon_got !== mon_exp) begin
                n_fail++;
                $display("FAIL scoreboard {pump,fault,valid,state}: got %b, expected %b (t=%0t)",
                         mon_got, mon_exp, $time);
            end
        end
    end

    initial begin
        int lvl;
        int len;
        int r;
        reset             = 1'b1;
        water_level_state = 3'b000;
        enable            = 1'b0;
        clear_fault       = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        expect_now("reset_outputs", int'({pump_on, fault, level_valid, ctrl_state}), 0);

        // Start from LOW: pump comes on at the fifth edge
        repeat (4) step(1, 1, 0);
        settle();
        expect_now("pump_before_accept", pump_on, 0);
        step(1, 1, 0);
        settle();
        expect_now("pump_start", pump_on, 1);
        expect_now("state_fill", ctrl_state, 1);
        step(1, 1, 0);

        // Hysteresis through MEDIUM, stop on HIGH, rest, refill
        repeat (6) step(2, 1, 0);
        repeat (4) step(4, 1, 0);
        settle();
        expect_now("pump_held_until_high", pump_on, 1);
        step(4, 1, 0);
        settle();
        expect_now("pump_off_on_high", pump_on, 0);
        expect_now("state_rest", ctrl_state, 2);
        repeat (5) step(4, 1, 0);
        settle();
        expect_now("rest_to_idle", ctrl_state, 0);
        repeat (5) step(1, 1, 0);
        settle();
        expect_now("refill", ctrl_state, 1);

        // Enable drop, then glitchy LOW while idle
        repeat (6) step(1, 0, 0);
        repeat (5) begin
            step(1, 0, 0);
            step(1, 0, 0);
            step(2, 0, 0);
        end
        settle();
        expect_now("glitch_level_valid", level_valid, 1);
        expect_now("glitch_state_idle", ctrl_state, 0);

        // Dry-run timeout holding MEDIUM, then clear
        step(1, 1, 0);
        repeat (24) step(2, 1, 0);
        settle();
        expect_now("timeout_fault", fault, 1);
        expect_now("timeout_pump", pump_on, 0);
        expect_now("timeout_state", ctrl_state, 3);
        step(2, 1, 1);
        settle();
        expect_now("clear_fault_rest", ctrl_state, 2);
        expect_now("clear_fault_flag", fault, 0);
        repeat (6) step(2, 1, 0);

        // Persistent invalid code, ignored clear, then recovery
        repeat (9) step(0, 1, 0);
        settle();
        expect_now("invalid_fault", fault, 1);
        step(0, 1, 1);
        settle();
        expect_now("clear_ignored_invalid", fault, 1);
        repeat (5) step(2, 0, 0);
        step(2, 0, 1);
        settle();
        expect_now("clear_after_valid", ctrl_state, 2);
        repeat (6) step(2, 0, 0);
        repeat (7) step(3, 0, 0);
        repeat (3) step(2, 0, 0);
        settle();
        expect_now("seven_invalid_no_fault", fault, 0);

        // Randomized segments of held codes
        repeat (120) begin
            r = $urandom_range(0, 9);
            if (r < 3)      lvl = 1;
            else if (r < 6) lvl = 2;
            else if (r < 8) lvl = 4;
            else if (r < 9) lvl = 0;
            else            lvl = 3 + 2 * $urandom_range(0, 2);
            len = $urandom_range(1, 8);
            repeat (len) step(lvl, $urandom_range(0, 9) != 0, $urandom_range(0, 7) == 0);
        end
        settle();

        // Asynchronous reset in the middle of a fill
        reset = 1'b1;
        model_reset();
        repeat (2) @(negedge clk);
        repeat (6) step(1, 1, 0);
        settle();
        expect_now("prereset_pump", pump_on, 1);
        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        expect_now("async_reset_outputs", int'({pump_on, fault, level_valid, ctrl_state}), 0);
        model_reset();
        repeat (2) @(negedge clk);

        expect_now("scoreboard_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
